display_scan_driver: RTL

Consumer end of the chess clock's seven-segment outputs. Takes the eight per-digit segment patterns (four per player) and the two player overflow flags. It time-multiplexes them onto one shared segment bus with eight one-hot digit enables, and inserts an anti-ghosting blank interval at the start of every digit slot. A player's four digits blink while that player's overflow flag is set.

---
 rtl/display_scan_driver.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/display_scan_driver.sv
// display_scan_driver
//   Time-multiplexes eight seven-segment digit patterns onto one shared
//   active-low segment bus with eight active-low one-hot digit enables.
//   Each digit slot begins with a blank interval to suppress ghosting.
//   A player's four digits blink while that player's overflow flag is set.
//
// Ports
//   CLK            system clock, rising edge
//   CLR            synchronous active-high reset (dominates CE)
//   CE             clock enable; all state advances only when high
//   seg0_0..seg0_3 player-0 digit patterns (1 = segment lit)
//   seg1_0..seg1_3 player-1 digit patterns (1 = segment lit)
//   OVERFLOW1      player-0 expired; blink digits 0-3
//   OVERFLOW2      player-1 expired; blink digits 4-7
//   SEGS           shared segment bus, active-low
//   AN             digit enables, active-low one-hot (8'hFF = all off)
//   FRAME          one-cycle pulse after the last slot of each frame
module display_scan_driver #(
  parameter int unsigned SCAN_DIV     = 4,
  parameter int unsigned BLANK_CYCLES = 1,
  parameter int unsigned BLINK_DIV    = 16
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       CE,
  input  logic [6:0] seg0_0,
  input  logic [6:0] seg0_1,
  input  logic [6:0] seg0_2,
  input  logic [6:0] seg0_3,
  input  logic [6:0] seg1_0,
  input  logic [6:0] seg1_1,
  input  logic [6:0] seg1_2,
  input  logic [6:0] seg1_3,
  input  logic       OVERFLOW1,
  input  logic       OVERFLOW2,
  output logic [6:0] SEGS,
  output logic [7:0] AN,
  output logic       FRAME
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] PRE_BLANK = PW'(BLANK_CYCLES);
  localparam logic [FW-1:0] FCNT_LAST = FW'(BLINK_DIV - 1);

  logic [PW-1:0] r_pre;
  logic [2:0]    r_idx;
  logic [FW-1:0] r_fcnt;
  logic          r_bph;
  logic [6:0]    r_lpat;
  logic          r_lblk;
  logic [6:0]    r_segs;
  logic [7:0]    r_an;
  logic          r_frame;

  logic          w_slot_end;
  logic          w_frame_end;
  logic [6:0]    w_pat;
  logic          w_ovf;

  assign w_slot_end  = (r_pre == PRE_LAST);
  assign w_frame_end = w_slot_end && (r_idx == 3'd7);

  always_comb begin
    w_pat = '0;
    unique case (r_idx)
      3'd0: w_pat = seg0_0;
      3'd1: w_pat = seg0_1;
      3'd2: w_pat = seg0_2;
      3'd3: w_pat = seg0_3;
      3'd4: w_pat = seg1_0;
      3'd5: w_pat = seg1_1;
      3'd6: w_pat = seg1_2;
      3'd7: w_pat = seg1_3;
    endcase
  end

  assign w_ovf = r_idx[2] ? OVERFLOW2 : OVERFLOW1;

  // Scan position, frame and blink counters
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_pre  <= '0;
      r_idx  <= '0;
      r_fcnt <= '0;
      r_bph  <= 1'b0;
    end else if (CE) begin
      r_pre <= w_slot_end ? '0 : r_pre + 1'b1;
      if (w_slot_end)
        r_idx <= r_idx + 3'd1;
      if (w_frame_end) begin
        if (r_fcnt == FCNT_LAST) begin
          r_fcnt <= '0;
          r_bph  <= ~r_bph;
        end else begin
          r_fcnt <= r_fcnt + 1'b1;
        end
      end
    end
  end

  // Pattern and blank flag are captured once per slot so input changes
  // mid-slot only show up on that digit's next slot.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_lpat <= '0;
      r_lblk <= 1'b0;
    end else if (CE && (r_pre == '0)) begin
      r_lpat <= w_pat;
      r_lblk <= r_bph & w_ovf;
    end
  end

  // Output register uses the pre-update pre/idx/lblk; the blank interval
  // at pre=0 hides the stale lpat on the latch cycle.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_an    <= '1;
      r_segs  <= '1;
      r_frame <= 1'b0;
    end else begin
      r_frame <= CE && w_frame_end;
      if (CE) begin
        if ((r_pre < PRE_BLANK) || r_lblk) begin
          r_an   <= '1;
          r_segs <= '1;
        end else begin
          r_an   <= ~(8'b1 << r_idx);
          r_segs <= ~r_lpat;
        end
      end
    end
  end

  assign SEGS  = r_segs;
  assign AN    = r_an;
  assign FRAME = r_frame;

endmodule
